// File: rtl/ula_arbitro.sv
// Purpose : shares one combinational ula between two requesters with round-robin arbitration.
// Latency : grant at edge t0, result captured at edge t0+L, ack high between t0+L and t0+L+1.
// Backpr. : requesters hold req/op/a/b until ack; no request is granted while EXEC or RESP.
//
// Ports:
//   clock, reset                 - single rising-edge clock, async active-high reset
//   reqN, opN, aN, bN, ackN      - requester N (0/1): request level, ALU code, operands, ack pulse
//   resultado                    - registered result, held until the next capture
//   ocupado                      - high whenever the FSM is not IDLE
//   ulaControle, ulaA, ulaB      - registered drive of the shared ula inputs
//   ulaSaida                     - combinational result returned by the ula
module ula_arbitro #(
    parameter int unsigned LAT_MULDIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic [3:0]  op0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    output logic        ack0,
    input  logic        req1,
    input  logic [3:0]  op1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        ack1,
    output logic [31:0] resultado,
    output logic        ocupado,
    output logic [3:0]  ulaControle,
    output logic [31:0] ulaA,
    output logic [31:0] ulaB,
    input  logic [31:0] ulaSaida
);

    localparam logic [3:0] OP_MUL      = 4'd12;
    localparam logic [3:0] OP_DIV      = 4'd13;
    // contador counts down to zero, so a multi-cycle op loads L-1
    localparam logic [3:0] CONT_MULDIV = 4'(LAT_MULDIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [3:0]  contador_q, contador_d;
    logic        vencedor_q, vencedor_d;
    logic        ultimo_q, ultimo_d;
    logic [31:0] resultado_q, resultado_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    logic        concede;
    logic        escolha;
    logic [3:0]  op_sel;
    logic [31:0] a_sel;
    logic [31:0] b_sel;
    logic        div_zero;

    always_comb begin
        concede = req0 | req1;
        escolha = req1 & (~req0 | ~ultimo_q);
        op_sel  = escolha ? op1 : op0;
        a_sel   = escolha ? a1  : a0;
        b_sel   = escolha ? b1  : b0;
        // the ula's own divide-by-zero output is not trusted; saturate instead
        div_zero = (ctrl_q == OP_DIV) && (b_q == 32'd0);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= IDLE;
            contador_q  <= 4'd0;
            vencedor_q  <= 1'b0;
            ultimo_q    <= 1'b1;
            resultado_q <= 32'd0;
            ctrl_q      <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            vencedor_q  <= vencedor_d;
            ultimo_q    <= ultimo_d;
            resultado_q <= resultado_d;
            ctrl_q      <= ctrl_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d    = estado_q;
        contador_d  = contador_q;
        vencedor_d  = vencedor_q;
        ultimo_d    = ultimo_q;
        resultado_d = resultado_q;
        ctrl_d      = ctrl_q;
        a_d         = a_q;
        b_d         = b_q;
        case (estado_q)
            IDLE: begin
                if (concede) begin
                    estado_d   = EXEC;
                    vencedor_d = escolha;
                    ultimo_d   = escolha;
                    ctrl_d     = op_sel;
                    a_d        = a_sel;
                    b_d        = b_sel;
                    contador_d = ((op_sel == OP_MUL) || (op_sel == OP_DIV)) ? CONT_MULDIV : 4'd0;
                end
            end
            EXEC: begin
                if (contador_q != 4'd0) begin
                    contador_d = contador_q - 4'd1;
                end else begin
                    resultado_d = div_zero ? 32'hFFFF_FFFF : ulaSaida;
                    estado_d    = RESP;
                end
            end
            RESP: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        ack0        = (estado_q == RESP) && !vencedor_q;
        ack1        = (estado_q == RESP) &&  vencedor_q;
        ocupado     = (estado_q != IDLE);
        resultado   = resultado_q;
        ulaControle = ctrl_q;
        ulaA        = a_q;
        ulaB        = b_q;
    end

endmodule

// File: doc/ula_arbitro.md
# ula_arbitro

Shares the single combinational `ula` between two requesters, for example the instruction datapath and a debug/DMA port, so that the datapath never instantiates a second ALU. Arbitrates requests round-robin and latches the operands into registers that drive the `ula` inputs. Holds each operation for a fixed number of cycles, one cycle for simple ops and `LAT_MULDIV` cycles for multiply/divide. Returns the registered result with a one-cycle acknowledge pulse to the winning requester.

## Interface
- `LAT_MULDIV`, default 4: execute cycles for ops 12 (mul) and 13 (div); legal range 1..15.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req0` in 1: requester 0 request level.
- `op0` in 4: requester 0 ALU control code.
- `a0` in 32: requester 0 operand A.
- `b0` in 32: requester 0 operand B.
- `ack0` out 1: one-cycle pulse; `resultado` is valid for requester 0 in this cycle.
- `req1`, `op1`, `a1`, `b1`, `ack1`: same as the requester 0 ports, for requester 1.
- `resultado` out 32: registered result; holds its value until the next capture.
- `ocupado` out 1: high whenever the FSM is not in IDLE.
- `ulaControle` out 4: to the `ula` control input; registered.
- `ulaA` out 32: to `ula` input A; registered.
- `ulaB` out 32: to `ula` input B; registered.
- `ulaSaida` in 32: from the `ula` output.

## Operation
- Op codes follow the `ula` encoding: 0 add, 1 sub, 2 and, 3 or, 4 not, 5 sr, 6 sl, 7 slt, 8 eq, 9 smt, 10 slteq, 11 smteq, 12 mul, 13 div. Codes 14 and 15 yield 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req` is high at a rising edge, pick the winner.
  - Latch the winner's `op`/`a`/`b` into `ulaControle`/`ulaA`/`ulaB`.
  - Record the winner in `vencedor`.
  - Load `contador` with L-1, where L = `LAT_MULDIV` for ops 12/13 and L = 1 otherwise.
  - Go to EXEC.
- EXEC:
  - `ula` inputs are held constant.
  - While `contador` != 0, decrement it.
  - When `contador` == 0, capture `ulaSaida` into `resultado` and go to RESP.
- Division by zero: for op 13 with `ulaB` == 0, capture 32'hFFFF_FFFF instead of `ulaSaida`. Latency is unchanged.
- RESP:
  - Assert `ack` of `vencedor` for exactly one cycle.
  - The other `ack` stays 0.
  - Go to IDLE unconditionally.
- Arbitration:
  - A 1-bit `ultimo` register records the last winner; it updates on every grant.
  - If both requesters are high, grant the one that is not `ultimo`.
  - If only one is high, grant it.
  - The reset value of `ultimo` is 1, so requester 0 wins the first tie.
- Requester rules:
  - Hold `req`, `op`, `a` and `b` stable until `ack`.
  - A `req` still high in the cycle after `ack` counts as a new request.
- Operand changes after the grant have no effect; operands are registered.
- All arithmetic is 32-bit unsigned. Mul keeps the low 32 bits. Div truncates.

## Timing
- Reset values:
  - `ack0`=0, `ack1`=0, `ocupado`=0.
  - `resultado`=0, `ulaControle`=0, `ulaA`=0, `ulaB`=0.
  - State=IDLE, `ultimo`=1, `contador`=0.
- Reset asserted mid-operation: return to IDLE immediately. No `ack` is issued for the aborted op, and that op is lost.
- Latency: request sampled at edge t0. `resultado` is captured at edge t0+L. `ack` is high between edges t0+L and t0+L+1.
- Simple op: `ack` is high in the cycle after edge t0+1.
- The earliest next grant is edge t0+L+2. Throughput is one op per L+2 cycles.
- `ocupado` rises after edge t0 and falls after edge t0+L+1.
- `ack0` and `ack1` are never high together.
- No request is granted while in EXEC or RESP.

## Test plan
- Reset, then `req0`=1, `op0`=0, `a0`=5, `b0`=7, held until ack → `ack0` pulses after 2 edges with `resultado`=12; `ack1` stays 0.
- `req1`=1, `op1`=12, `a1`=6, `b1`=7, `LAT_MULDIV`=4 → `ack1` after 5 edges with `resultado`=42; `ocupado` high for exactly 5 cycles.
- `req0` and `req1` both held high, ops 1 and 3 → grants alternate 0,1,0,1 across 4 ops; results match per requester.
- op 13, A=100, B=0 → `resultado`=32'hFFFF_FFFF after L+1 edges. Then op 13, A=100, B=7 → `resultado`=14.
- Assert `reset` during EXEC of a mul → no `ack` is issued and all outputs are 0. A fresh `req0` add after reset completes normally.
- op 15 with any operands → `resultado`=0 and latency 1.
